// File: rtl/app_update.sv
// Layered min-sum APP update stage: forms q = APP - r_old for the CNU, buffers q
// per row, and writes APP_new = q + r_new back when the CNU returns the row.
module app_update #(
  parameter int D     = 7,
  parameter int res_w = 6,
  parameter int ext_w = 3,
  parameter int DEPTH = 8,
  parameter int cnt_w = 4,
  localparam int data_w = res_w + ext_w
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [data_w*D-1:0]   app_in,
  input  logic [res_w*D-1:0]    r_old,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_w*D-1:0]   q,
  output logic                  q_valid,
  input  logic [res_w*D-1:0]    r_new,
  input  logic                  r_valid,
  output logic [data_w*D-1:0]   app_out,
  output logic                  app_valid,
  output logic                  err_underflow
);

  localparam int ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [data_w*D-1:0] fifo_mem [DEPTH];
  logic [ptr_w-1:0]    wr_ptr, rd_ptr;
  logic [cnt_w-1:0]    count;
  logic                push, pop, empty;
  logic [data_w*D-1:0] q_p0, sum_p0, fifo_rd;

  function automatic logic signed [data_w:0] sext_d(input logic [data_w-1:0] x);
    return {x[data_w-1], x};
  endfunction

  function automatic logic signed [data_w:0] sext_r(input logic [res_w-1:0] x);
    return {{(ext_w+1){x[res_w-1]}}, x};
  endfunction

  // Symmetric clamp: the most negative code is never emitted so negation stays safe.
  function automatic logic [data_w-1:0] sat_sym(input logic signed [data_w:0] x);
    logic signed [data_w:0] lim, nlim;
    lim  = {2'b00, {(data_w-1){1'b1}}};
    nlim = -lim;
    if (x > lim)       return lim[data_w-1:0];
    else if (x < nlim) return nlim[data_w-1:0];
    else               return x[data_w-1:0];
  endfunction

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign pop      = en & r_valid & ~empty;
  assign in_ready = (count < cnt_w'(DEPTH)) | pop;
  assign push     = en & in_valid & in_ready;
  assign fifo_rd  = fifo_mem[rd_ptr];

  // Stage p0: per-edge subtract / add with saturation
  always_comb begin
    q_p0   = '0;
    sum_p0 = '0;
    for (int i = 0; i < D; i++) begin
      q_p0[i*data_w +: data_w]   = sat_sym(sext_d(app_in[i*data_w +: data_w])
                                           - sext_r(r_old[i*res_w +: res_w]));
      sum_p0[i*data_w +: data_w] = sat_sym(sext_d(fifo_rd[i*data_w +: data_w])
                                           + sext_r(r_new[i*res_w +: res_w]));
    end
  end

  // Stage p1: registered outputs, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      q             <= '0;
      app_out       <= '0;
      q_valid       <= 1'b0;
      app_valid     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      q_valid   <= push;
      app_valid <= pop;
      if (push) begin
        q      <= q_p0;
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        app_out <= sum_p0;
        rd_ptr  <= next_ptr(rd_ptr);
      end
      if (en & r_valid & empty)
        err_underflow <= 1'b1;
      if (push & ~pop)
        count <= count + 1'b1;
      else if (pop & ~push)
        count <= count - 1'b1;
    end
  end

  // Buffer storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= q_p0;
  end

endmodule

// File: doc/app_update.md
Name: app_update

Overview:
- Layered min-sum decoder stage that wraps the check-node unit.
- Forward path: subtracts the previous check-to-variable message r_old from each posterior LLR (APP) to form the variable-to-check message q, which is fed to the CNU.
- Each q word is also buffered in an internal FIFO. When the CNU returns r_new for that row, the block pops the matching q and forms APP_new = q + r_new, which is written back to APP memory.
- Saturating arithmetic is used on both paths.

Parameters:
- D, 7, row degree (edges per check node)
- res_w, 6, width of r messages (two's complement)
- ext_w, 3, extra q/APP bits; data_w = res_w + ext_w
- DEPTH, 8, FIFO depth in rows (must cover CNU latency plus pipelining slack)
- cnt_w, 4, FIFO occupancy counter width, >= log2(DEPTH)+1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  global stage enable; when 0 all state holds
- app_in  in  data_w*D  posterior LLRs for current row, edge i at [i*data_w +: data_w]
- r_old  in  res_w*D  previous r messages for current row
- in_valid  in  1  app_in/r_old valid
- in_ready  out  1  row accepted this cycle when in_valid & in_ready & en
- q  out  data_w*D  q messages to CNU
- q_valid  out  1  q valid (single-cycle pulse per accepted row)
- r_new  in  res_w*D  new r messages from CNU
- r_valid  in  1  r_new valid
- app_out  out  data_w*D  updated APP LLRs
- app_valid  out  1  app_out valid (pulse)
- err_underflow  out  1  sticky: r_valid arrived with no buffered q

Behaviour:
- Reset (rst==0 at a clock edge): q, app_out, q_valid, app_valid, err_underflow and the FIFO read/write pointers and count all go to 0. in_ready reads 1 after reset. A reset mid-row discards all buffered rows.
- en==0: no push, no pop, registers hold, q_valid and app_valid forced to 0.
- in_ready = (count < DEPTH) | pop_this_cycle. Push and pop in the same cycle at full are legal; count is unchanged.
- Forward path (latency 1):
  - On accept, per edge, diff = sext(app_in_i, data_w+1) - sext(r_old_i, data_w+1).
  - q_i is registered as the symmetric saturation of diff to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], i.e. ±255 for defaults.
  - q_valid=1 on the following cycle.
  - The same saturated q words are written into FIFO[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Return path (latency 1):
  - On r_valid & en with count>0: pop FIFO[rd_ptr] (rd_ptr wraps modulo DEPTH).
  - sum_i = sext(fifo_q_i) + sext(r_new_i), saturated symmetrically to data_w.
  - app_out is registered and app_valid=1 on the next cycle.
- Underflow: r_valid with count==0 and no same-cycle push produces no pop and app_valid=0. err_underflow sets and stays set until reset.
  - A same-cycle push does not bypass into the pop; the FIFO is strictly registered.
- Ordering: rows are returned strictly FIFO. The CNU must return r rows in issue order.
- Counter: count increments on push only, decrements on pop only, and holds on both or neither. It never exceeds DEPTH.
- The value -2^(data_w-1) is never produced on q or app_out.

Test Plan:
- Reset then single row: app_in all edges = +100, r_old = +20, in_valid one cycle -> next cycle q_valid=1, q all = +80. Three cycles later r_new all = -31 with r_valid -> next cycle app_out all = +49, app_valid=1.
- Saturation: app_in edge0 = +250, r_old edge0 = -32 -> q edge0 = +255. Return r_new edge0 = +31 -> app_out edge0 = +255. Also app_in = -256 with r_old = 0 -> q = -255.
- Full FIFO: push DEPTH=8 rows with no r_valid -> in_ready=0, and a 9th in_valid is not accepted (no q_valid). Then r_valid and in_valid in the same cycle -> both accepted, count stays 8.
- Ordering/wrap: stream 20 rows with distinct app_in values (row k edges = k), returning r_new=0 with varying delays of 1-5 cycles -> app_out sequence equals 0..19 in order across pointer wrap.
- Underflow: after reset, assert r_valid with an empty FIFO -> app_valid stays 0, err_underflow=1 and remains 1 through later normal traffic until rst=0.
- Enable/reset mid-op: buffer 3 rows, drop en for 4 cycles while driving in_valid/r_valid -> no state change, no valid pulses. Then pulse rst=0 for one cycle -> count=0, in_ready=1, and a following r_valid gives underflow.
